// File: rtl/sys_reset_seq.sv
// ---------------------------------------------------------------------------
// sys_reset_seq
//   System reset sequencer placed directly after the system PLL. It runs on the
//   PLL 0-degree fast output (CLKOP, 85.9091 MHz). The block waits until PLL
//   lock has been continuously present for LOCK_CYCLES, then keeps the core in
//   reset for HOLD_CYCLES more before it releases it. A debounced user button
//   re-enters the hold phase. While running, the block produces /2 and /4
//   clock enables that are phase-aligned to the release of reset.
//
// Ports
//   clk         in   PLL CLKOP, the only clock
//   reset       in   synchronous, active-high block reset
//   pll_locked  in   PLL lock flag, asynchronous, synchronised internally
//   btn_reset   in   user reset button, active-high, asynchronous, bouncy
//   sys_reset   out  synchronous active-high reset to the core
//   ce_2        out  one-cycle enable on every 2nd clk while running
//   ce_4        out  one-cycle enable on every 4th clk while running
//   ready       out  high only in RUN
//   state_dbg   out  current FSM state (0 WAIT_LOCK, 1 STABILIZE, 2 HOLD, 3 RUN)
// ---------------------------------------------------------------------------
module sys_reset_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_CYCLES     = 1024,
    parameter int HOLD_CYCLES     = 256,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       btn_reset,
    output logic       sys_reset,
    output logic       ce_2,
    output logic       ce_4,
    output logic       ready,
    output logic [1:0] state_dbg
);

    // One counter serves both STABILIZE and HOLD, so it is sized for the larger.
    localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ARM    = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lk_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   lk_s;
    logic                   btn_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_sync  <= '0;
            btn_sync <= '0;
        end else begin
            lk_sync  <= {lk_sync[SYNC_STAGES-2:0], pll_locked};
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_reset};
        end
    end

    assign lk_s  = lk_sync[SYNC_STAGES-1];
    assign btn_s = btn_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Button debounce
    //   btn_q holds the previous synchronised sample, so db_cnt measures how
    //   long btn_s has been steady. The counter saturates at DEBOUNCE_CYCLES-1.
    //   press is raised only on the cycle the count reaches that value with the
    //   button high, which gives one pulse per press however long the button is
    //   held.
    // -----------------------------------------------------------------------
    logic            btn_q;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            btn_q <= btn_s;
            press <= 1'b0;
            if (btn_s != btn_q) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_LAST) begin
                db_cnt <= db_cnt + DB_ONE;
                press  <= btn_s && (db_cnt == DB_ARM);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM: state register, next-state logic, output logic
    // -----------------------------------------------------------------------
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       ph;
    logic [1:0]       ph_nx;
    logic             sys_reset_nx;
    logic             ready_nx;
    logic             ce_2_nx;
    logic             ce_4_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            ph        <= '0;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            ce_2      <= 1'b0;
            ce_4      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ph        <= ph_nx;
            sys_reset <= sys_reset_nx;
            ready     <= ready_nx;
            ce_2      <= ce_2_nx;
            ce_4      <= ce_4_nx;
        end
    end

    // Within every state, lock loss is checked before press, and press before
    // the terminal count.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            WAIT_LOCK: begin
                cnt_nx = '0;
                if (lk_s) begin
                    state_nx = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!lk_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (!lk_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (press) begin
                    cnt_nx = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lk_s) begin
                    state_nx = WAIT_LOCK;
                end else if (press) begin
                    state_nx = HOLD;
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end
        endcase
    end

    // The enables use the current phase, so the first ce_2 appears two cycles
    // after ready rises and the first ce_4 four cycles after. Gating them with
    // state_nx makes both enables drop on the same edge at which sys_reset
    // rises when RUN is left.
    always_comb begin
        sys_reset_nx = (state_nx != RUN);
        ready_nx     = (state_nx == RUN);
        ph_nx        = (state == RUN) ? ph + 2'd1 : 2'd0;
        ce_2_nx      = (state == RUN) && (state_nx == RUN) && ph[0];
        ce_4_nx      = (state == RUN) && (state_nx == RUN) && (ph == 2'd3);
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sys_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_sys_reset_seq
//   Directed and randomised bench for sys_reset_seq with small parameters.
//   The reference model works from recorded input history: synchronised
//   inputs are looked up by cycle index, press detection is a run length of
//   consecutive high button samples, and the sequencer phases are timed from
//   the cycle at which each phase was entered.
// ---------------------------------------------------------------------------
module tb_sys_reset_seq;

    localparam int SYNC  = 2;
    localparam int LOCK  = 8;
    localparam int HOLDC = 4;
    localparam int DEB   = 4;
    localparam int HIST  = 4096;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       btn_reset;
    logic       sys_reset;
    logic       ce_2;
    logic       ce_4;
    logic       ready;
    logic [1:0] state_dbg;

    sys_reset_seq #(
        .SYNC_STAGES     (SYNC),
        .LOCK_CYCLES     (LOCK),
        .HOLD_CYCLES     (HOLDC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .btn_reset  (btn_reset),
        .sys_reset  (sys_reset),
        .ce_2       (ce_2),
        .ce_4       (ce_4),
        .ready      (ready),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Input history indexed by clock edge number.
    bit pll_at [HIST];
    bit btn_at [HIST];
    int last_rst = 0;

    // Model state.
    int m_state   = 0;
    int m_enter   = 0;
    int m_run_at  = 0;
    int m_btn_run = 0;
    bit m_press   = 1'b0;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Synchronised value visible after edge n.
    function automatic bit lks(input int n);
        return (n - last_rst >= SYNC) ? pll_at[n-SYNC+1] : 1'b0;
    endfunction

    function automatic bit btns(input int n);
        return (n - last_rst >= SYNC) ? btn_at[n-SYNC+1] : 1'b0;
    endfunction

    task automatic model_step(input bit rst);
        bit lk_pre;
        bit press_pre;
        if (rst) begin
            last_rst  = cyc;
            m_state   = 0;
            m_enter   = cyc;
            m_btn_run = 0;
            m_press   = 1'b0;
        end else begin
            lk_pre    = lks(cyc - 1);
            press_pre = m_press;
            m_press   = (m_btn_run == DEB);
            m_btn_run = btns(cyc) ? m_btn_run + 1 : 0;
            case (m_state)
                0: if (lk_pre) begin m_state = 1; m_enter = cyc; end
                1: begin
                    if (!lk_pre) m_state = 0;
                    else if (cyc - m_enter == LOCK) begin m_state = 2; m_enter = cyc; end
                end
                2: begin
                    if (!lk_pre) m_state = 0;
                    else if (press_pre) m_enter = cyc;
                    else if (cyc - m_enter == HOLDC) begin m_state = 3; m_run_at = cyc; end
                end
                default: begin
                    if (!lk_pre) m_state = 0;
                    else if (press_pre) begin m_state = 2; m_enter = cyc; end
                end
            endcase
        end
    endtask

    task automatic tick();
        bit run_now;
        int age;
        @(posedge clk);
        cyc++;
        if (cyc >= HIST) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HIST);
            $fatal(1, "cycle budget exhausted");
        end
        pll_at[cyc] = pll_locked;
        btn_at[cyc] = btn_reset;
        model_step(reset);
        #1;
        run_now = (m_state == 3);
        age     = cyc - m_run_at;
        chk("sys_reset", {1'b0, sys_reset}, {1'b0, !run_now});
        chk("ready",     {1'b0, ready},     {1'b0, run_now});
        chk("state_dbg", state_dbg,         2'(m_state));
        chk("ce_2", {1'b0, ce_2}, {1'b0, run_now && age > 0 && (age % 2 == 0)});
        chk("ce_4", {1'b0, ce_4}, {1'b0, run_now && age > 0 && (age % 4 == 0)});
    endtask

    // Times each milestone of the start-up sequence from edge 'base'.
    task automatic run_to_ready(input int base, input string tag);
        int t_st, t_hd, t_rdy, t_c2, t_c4;
        logic [1:0] prev;
        t_st = -1; t_hd = -1; t_rdy = -1; t_c2 = -1; t_c4 = -1;
        prev = state_dbg;
        for (int i = 0; i < 60 && t_c4 < 0; i++) begin
            tick();
            if (t_st  < 0 && state_dbg == 2'd1 && prev != 2'd1) t_st = cyc - base;
            if (t_hd  < 0 && state_dbg == 2'd2 && prev != 2'd2) t_hd = cyc - base;
            if (t_rdy < 0 && ready) t_rdy = cyc - base;
            if (t_c2  < 0 && ce_2)  t_c2  = cyc - base;
            if (t_c4  < 0 && ce_4)  t_c4  = cyc - base;
            prev = state_dbg;
        end
        chk_int({tag, "_stabilize_at"}, t_st, 3);
        chk_int({tag, "_hold_at"},      t_hd, 11);
        chk_int({tag, "_ready_at"},     t_rdy, 15);
        chk_int({tag, "_ce2_at"},       t_c2, 17);
        chk_int({tag, "_ce4_at"},       t_c4, 19);
    endtask

    initial begin
        int t, r, d, hi_cnt, first_hi, k;

        // 1: reset then no lock.
        reset = 1'b1; pll_locked = 1'b0; btn_reset = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();

        // 2: lock rises, full start-up sequence and enable cadence.
        t = cyc;
        pll_locked = 1'b1;
        run_to_ready(t, "startup");
        repeat (12) tick();

        // 3: one-cycle lock dip inside STABILIZE, first at cnt=5, then random.
        for (int n = 0; n < 4; n++) begin
            pll_locked = 1'b0;
            repeat (5) tick();
            t = cyc;
            pll_locked = 1'b1;
            d = (n == 0) ? 6 : int'($urandom_range(1, 7));
            repeat (d) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            r = cyc;
            run_to_ready(r, "relock");
        end

        // 4: bouncing button in RUN, then a steady press held down.
        repeat ($urandom_range(0, 5)) tick();
        for (int i = 0; i < 10; i++) begin
            btn_reset = (i % 2 == 0);
            tick();
        end
        btn_reset = 1'b1;
        t = cyc;
        hi_cnt = 0; first_hi = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sys_reset) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc - t;
            end
        end
        chk_int("press_reset_len", hi_cnt, HOLDC);
        chk_int("press_reset_at",  first_hi, 7);
        btn_reset = 1'b0;
        repeat (10) tick();

        // 4b: random button noise; the model decides whether a press occurs.
        for (int i = 0; i < 12; i++) begin
            btn_reset = $urandom_range(0, 1) != 0;
            tick();
        end
        btn_reset = 1'b0;
        repeat (15) tick();

        // 5: lock loss in RUN.
        k = 0;
        for (int i = 0; i < 40 && !ready; i++) tick();
        repeat ($urandom_range(0, 5)) tick();
        t = cyc;
        pll_locked = 1'b0;
        for (int i = 0; i < 10 && k == 0; i++) begin
            tick();
            if (sys_reset) k = cyc - t;
        end
        chk_int("lockloss_reset_at", k, 3);
        repeat (4) tick();

        // 5b: press and lock loss seen on the same edge in HOLD.
        t = cyc;
        pll_locked = 1'b1;
        repeat (6) tick();
        btn_reset = 1'b1;
        repeat (4) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        chk("coincide_state", state_dbg, 2'd0);
        btn_reset = 1'b0;
        repeat (8) tick();

        // 6: block reset mid-HOLD, then mid-RUN; sequence must restart cleanly.
        t = cyc;
        pll_locked = 1'b1;
        repeat (12) tick();
        chk("mid_hold_state", state_dbg, 2'd2);
        reset = 1'b1;
        tick();
        chk("rst_hold_sys_reset", {1'b0, sys_reset}, 2'd1);
        reset = 1'b0;
        r = cyc;
        run_to_ready(r, "after_rst_hold");
        repeat ($urandom_range(2, 9)) tick();
        reset = 1'b1;
        tick();
        chk("rst_run_ready", {1'b0, ready}, 2'd0);
        reset = 1'b0;
        r = cyc;
        run_to_ready(r, "after_rst_run");
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
